tmu2_burst: RTL and testbench
=============================

TMU2_BURST -- requirements
Module: tmu2_burst

Interface
REQ-001 SHALL have parameter fml_depth, default 26, FML byte-address width.
REQ-002 SHALL have port sys_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  in  1  level request to evict the partial burst at end of frame.
REQ-005 SHALL have port busy  out  1  high while the buffer or output holds data.
REQ-006 SHALL have port pipe_stb_i  in  1  pixel valid from the upstream decay stage.
REQ-007 SHALL have port pipe_ack_o  out  1  pixel accepted this cycle.
REQ-008 SHALL have port color  in  16  RGB565 pixel.
REQ-009 SHALL have port dadr  in  fml_depth-1  destination pixel address (16-bit units).
REQ-010 SHALL have port pipe_stb_o  out  1  burst valid.
REQ-011 SHALL have port pipe_ack_i  in  1  burst consumed by the FML writer.
REQ-012 SHALL have port burst_addr  out  fml_depth-5  burst tag, equal to dadr[fml_depth-2:4].
REQ-013 SHALL have port burst_sel  out  16  per-pixel write enable.
REQ-014 SHALL have port burst_do  out  256  burst data, 16 pixels.

Function
REQ-015 SHALL hold one assembly buffer (tag, 16x16 data, 16-bit sel) and one output register (addr, sel, data, valid).
REQ-016 Pixel index i=dadr[3:0] SHALL map to burst_do[255-16i:240-16i] and burst_sel bit 15-i.
REQ-017 Buffer is empty when sel==0; hit = pipe_stb_i & non-empty & dadr[fml_depth-2:4]==tag.
REQ-018 out_free = ~pipe_stb_o | pipe_ack_i.
REQ-019 pipe_ack_o SHALL be 1 when the buffer is empty, on a hit, or when out_free; otherwise 0.
REQ-020 An accepted hit or empty-buffer pixel SHALL write color into slot i, set sel bit, and load tag if empty.
REQ-021 An accepted miss (non-empty, tag differs) SHALL move the buffer to the output register and reload the buffer with only the new pixel, in the same edge.
REQ-022 A rewrite of an already-set slot SHALL overwrite the data; the last write wins.
REQ-023 With flush=1, pipe_stb_i=0, a non-empty buffer and out_free, the buffer SHALL move to the output register and clear.
REQ-024 A pixel arriving with flush=1 SHALL take priority; eviction by flush SHALL be deferred.
REQ-025 pipe_stb_o SHALL rise the cycle after an eviction edge and remain stable, with all fields frozen, until pipe_ack_i.
REQ-026 On pipe_ack_i with no concurrent eviction, pipe_stb_o SHALL fall the next cycle; ack and eviction on the same edge SHALL keep pipe_stb_o high with the new burst.
REQ-027 busy = (sel!=0) | pipe_stb_o.
REQ-028 Latency from the eviction-triggering event to pipe_stb_o SHALL be exactly 1 cycle.

Reset
REQ-029 sys_rst SHALL clear the buffer sel, the output valid and the timeout counter, discarding any partial burst; pipe_stb_o=0, busy=0, and pipe_ack_o=1 the next cycle.
REQ-030 Data and tag registers SHALL NOT require reset.

Configuration
REQ-031 With TMU2_BURST_TIMEOUT_EN defined, a 6-bit idle counter SHALL clear on each accepted pixel and increment, saturating at 63, while the buffer is non-empty.
REQ-032 With TMU2_BURST_TIMEOUT_EN defined and the counter at 63, pipe_stb_i=0 and out_free, the buffer SHALL be evicted as by flush.
REQ-033 Without TMU2_BURST_TIMEOUT_EN, no counter SHALL exist; eviction occurs only on miss or flush.

Verification
REQ-034 Send 16 pixels, tag 5, idx 0..15, then flush: one burst with burst_addr=5, sel=0xFFFF, and data in index order.
REQ-035 Send tag 1 idx 3 then tag 2 idx 0: burst addr 1, sel=0x1000; the buffer then holds tag 2 with sel=0x8000.
REQ-036 With pipe_ack_i held 0 and the output full, a miss pixel: pipe_ack_o=0 until pipe_ack_i=1, and no data is lost.
REQ-037 Send idx 7 twice, colors 0x1111 then 0x2222, then flush: sel=0x0100 and slot 7 holds 0x2222.
REQ-038 Assert sys_rst with a partial buffer and the output valid: next cycle pipe_stb_o=0 and busy=0; a later flush emits nothing.
REQ-039 TMU2_BURST_TIMEOUT_EN: send one pixel, then idle: the burst is evicted 64 cycles after acceptance, and pipe_stb_o=1 one cycle later.

Source files
------------

// File: rtl/tmu2_burst.sv
// Burst assembler: gathers 16-bit pixels into 16-pixel write bursts for the FML writer.
// Optional idle-timeout eviction is enabled by defining TMU2_BURST_TIMEOUT_EN.
module tmu2_burst #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 flush,
    output logic                 busy,
    input  logic                 pipe_stb_i,
    output logic                 pipe_ack_o,
    input  logic [15:0]          color,
    input  logic [fml_depth-2:0] dadr,
    output logic                 pipe_stb_o,
    input  logic                 pipe_ack_i,
    output logic [fml_depth-6:0] burst_addr,
    output logic [15:0]          burst_sel,
    output logic [255:0]         burst_do
);
    localparam int TW = fml_depth - 5;

    logic [TW-1:0]  tag_q, tag_d;
    logic [15:0]    sel_q, sel_d;
    logic [15:0]    data_q [16];
    logic [15:0]    data_d [16];
    logic [TW-1:0]  out_addr_q, out_addr_d;
    logic [15:0]    out_sel_q, out_sel_d;
    logic [255:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic [TW-1:0]  pix_tag;
    logic [3:0]     pix_idx;
    logic [15:0]    pix_onehot;
    logic [255:0]   buf_flat;
    logic           buf_empty;
    logic           tag_hit;
    logic           hit;
    logic           out_free;
    logic           accept;
    logic           miss;
    logic           timeout_hit;
    logic           idle_evict;
    logic           evict;

    assign pix_tag    = dadr[fml_depth-2:4];
    assign pix_idx    = dadr[3:0];
    assign pix_onehot = 16'h8000 >> pix_idx;

    // Slot 0 sits in the most significant lane of the burst.
    for (genvar gi = 0; gi < 16; gi++) begin : g_flat
        assign buf_flat[255-16*gi -: 16] = data_q[gi];
    end

    assign buf_empty  = (sel_q == 16'h0);
    assign tag_hit    = (pix_tag == tag_q);
    assign hit        = pipe_stb_i & ~buf_empty & tag_hit;
    assign out_free   = ~out_valid_q | pipe_ack_i;
    assign pipe_ack_o = buf_empty | hit | out_free;
    assign accept     = pipe_stb_i & pipe_ack_o;
    assign miss       = accept & ~buf_empty & ~tag_hit;
    // An incoming pixel always wins over a flush/timeout eviction.
    assign idle_evict = ~pipe_stb_i & ~buf_empty & out_free & (flush | timeout_hit);
    assign evict      = miss | idle_evict;

`ifdef TMU2_BURST_TIMEOUT_EN
    logic [5:0] idle_cnt_q, idle_cnt_d;

    assign timeout_hit = (idle_cnt_q == 6'd63);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (accept || buf_empty) begin
            idle_cnt_d = 6'd0;
        end else if (idle_cnt_q != 6'd63) begin
            idle_cnt_d = idle_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idle_cnt_q <= 6'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        tag_d       = tag_q;
        sel_d       = sel_q;
        data_d      = data_q;
        out_addr_d  = out_addr_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            tag_d           = pix_tag;
            data_d[pix_idx] = color;
            sel_d           = (miss ? 16'h0 : sel_q) | pix_onehot;
        end else if (idle_evict) begin
            sel_d = 16'h0;
        end

        if (evict) begin
            out_addr_d  = tag_q;
            out_sel_d   = sel_q;
            out_data_d  = buf_flat;
            out_valid_d = 1'b1;
        end else if (pipe_ack_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel_q       <= 16'h0;
            out_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload registers are qualified by sel/valid, so they carry no reset.
    always_ff @(posedge sys_clk) begin
        tag_q      <= tag_d;
        data_q     <= data_d;
        out_addr_q <= out_addr_d;
        out_sel_q  <= out_sel_d;
        out_data_q <= out_data_d;
    end

    assign pipe_stb_o = out_valid_q;
    assign burst_addr = out_addr_q;
    assign burst_sel  = out_sel_q;
    assign burst_do   = out_data_q;
    assign busy       = ~buf_empty | out_valid_q;

endmodule

// File: tb/tb_tmu2_burst.sv
// Self-checking bench for tmu2_burst: per-cycle comparison against a burst-level model
// plus directed scenarios with literal expectations.
module tb_tmu2_burst;
    localparam int FD = 26;

    logic          clk;
    logic          sys_rst;
    logic          flush;
    logic          busy;
    logic          pipe_stb_i;
    logic          pipe_ack_o;
    logic [15:0]   color;
    logic [FD-2:0] dadr;
    logic          pipe_stb_o;
    logic          pipe_ack_i;
    logic [FD-6:0] burst_addr;
    logic [15:0]   burst_sel;
    logic [255:0]  burst_do;

    tmu2_burst #(.fml_depth(FD)) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .flush      (flush),
        .busy       (busy),
        .pipe_stb_i (pipe_stb_i),
        .pipe_ack_o (pipe_ack_o),
        .color      (color),
        .dadr       (dadr),
        .pipe_stb_o (pipe_stb_o),
        .pipe_ack_i (pipe_ack_i),
        .burst_addr (burst_addr),
        .burst_sel  (burst_sel),
        .burst_do   (burst_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: the buffer is a set of pixels belonging to one burst tag; the output
    // is one finished burst waiting for the writer.
    logic [20:0]  m_tag;
    logic [15:0]  m_sel;
    logic [15:0]  m_pix [16];
    bit           m_ov;
    logic [20:0]  m_oaddr;
    logic [15:0]  m_osel;
    logic [255:0] m_odata;
    int           m_idle;

    function automatic bit exp_ack();
        return (m_sel == 16'h0) || (pipe_stb_i && (dadr[24:4] == m_tag)) || !m_ov || pipe_ack_i;
    endfunction

    function automatic logic [255:0] lane_mask(input logic [15:0] s);
        logic [255:0] m = '0;
        for (int k = 0; k < 16; k++) if (s[15-k]) m[255-16*k -: 16] = 16'hFFFF;
        return m;
    endfunction

    always @(posedge clk) begin : model
        bit a, ship, timed_out;
        if (sys_rst) begin
            m_sel = 16'h0;
            m_ov = 1'b0;
            m_idle = 0;
        end else begin
            a = pipe_stb_i && exp_ack();
`ifdef TMU2_BURST_TIMEOUT_EN
            timed_out = (m_idle >= 63);
`else
            timed_out = 1'b0;
`endif
            ship = 1'b0;
            if (a && m_sel != 16'h0 && dadr[24:4] != m_tag) ship = 1'b1;
            if (!pipe_stb_i && m_sel != 16'h0 && (!m_ov || pipe_ack_i) && (flush || timed_out))
                ship = 1'b1;
            if (ship) begin
                m_oaddr = m_tag;
                m_osel = m_sel;
                for (int k = 0; k < 16; k++) m_odata[255-16*k -: 16] = m_pix[k];
                m_ov = 1'b1;
            end else if (pipe_ack_i) begin
                m_ov = 1'b0;
            end
            if (a || m_sel == 16'h0) m_idle = 0;
            else if (m_idle < 63) m_idle++;
            if (ship && !a) m_sel = 16'h0;
            if (a) begin
                if (dadr[24:4] != m_tag) m_sel = 16'h0;
                m_tag = dadr[24:4];
                m_pix[dadr[3:0]] = color;
                m_sel[15 - dadr[3:0]] = 1'b1;
            end
        end
    end

    logic [20:0]  q_addr [$];
    logic [15:0]  q_sel  [$];
    logic [255:0] q_data [$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack_o", pipe_ack_o, exp_ack());
            chk("busy", busy, (m_sel != 16'h0) || m_ov);
            chk("stb_o", pipe_stb_o, m_ov);
            if (m_ov) begin
                chk("burst_addr", burst_addr, m_oaddr);
                chk("burst_sel", burst_sel, m_osel);
                chk("burst_do", burst_do & lane_mask(m_osel), m_odata & lane_mask(m_osel));
            end
            if (pipe_stb_o && pipe_ack_i) begin
                q_addr.push_back(burst_addr);
                q_sel.push_back(burst_sel);
                q_data.push_back(burst_do);
                $display("burst addr=%0h sel=%h", burst_addr, burst_sel);
            end
        end
    end

    task automatic send_pix(input logic [20:0] t, input logic [3:0] i, input logic [15:0] c);
        bit ok;
        int n = 0;
        pipe_stb_i = 1'b1;
        dadr = {t, i};
        color = c;
        do begin
            @(negedge clk);
            ok = pipe_ack_o;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 1'b0, 1'b1);
        pipe_stb_i = 1'b0;
        $display("pixel tag=%0h idx=%0d color=%h", t, i, c);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_sel.delete();
        q_data.delete();
    endtask

    initial begin
        logic [255:0] exp_d;
        int n;
        sys_rst = 1'b1;
        flush = 1'b0;
        pipe_stb_i = 1'b0;
        color = '0;
        dadr = '0;
        pipe_ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_stb_o", pipe_stb_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack_o", pipe_ack_o, 1'b1);
        @(posedge clk);
        #1;

        // Full burst, tag 5
        clear_q();
        for (int i = 0; i < 16; i++) send_pix(21'd5, 4'(i), 16'h1000 + 16'(i));
        do_flush();
        idle(3);
        chk("full_count", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
            exp_d = '0;
            for (int k = 0; k < 16; k++) exp_d[255-16*k -: 16] = 16'h1000 + 16'(k);
            chk("full_addr", q_addr[0], 21'd5);
            chk("full_sel", q_sel[0], 16'hFFFF);
            chk("full_data", q_data[0], exp_d);
        end

        // Miss eviction
        clear_q();
        send_pix(21'd1, 4'd3, 16'hAAAA);
        send_pix(21'd2, 4'd0, 16'hBBBB);
        idle(2);
        chk("miss_count", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
            chk("miss_addr", q_addr[0], 21'd1);
            chk("miss_sel", q_sel[0], 16'h1000);
            chk("miss_slot3", q_data[0][207:192], 16'hAAAA);
        end
        do_flush();
        idle(3);
        chk("miss2_count", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            chk("miss2_addr", q_addr[1], 21'd2);
            chk("miss2_sel", q_sel[1], 16'h8000);
            chk("miss2_slot0", q_data[1][255:240], 16'hBBBB);
        end

        // Back-pressure with a full output register
        clear_q();
        pipe_ack_i = 1'b0;
        send_pix(21'd3, 4'd0, 16'h3333);
        send_pix(21'd4, 4'd1, 16'h4444);
        pipe_stb_i = 1'b1;
        dadr = {21'd6, 4'd2};
        color = 16'h6666;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ack_o_low", pipe_ack_o, 1'b0);
            chk("bp_stb_o_high", pipe_stb_o, 1'b1);
            @(posedge clk);
            #1;
        end
        pipe_ack_i = 1'b1;
        @(negedge clk);
        chk("bp_ack_o_high", pipe_ack_o, 1'b1);
        @(posedge clk);
        #1;
        pipe_stb_i = 1'b0;
        @(negedge clk);
        chk("bp_stb_kept", pipe_stb_o, 1'b1);
        chk("bp_new_addr", burst_addr, 21'd4);
        @(posedge clk);
        #1;
        do_flush();
        idle(3);
        chk("bp_count", q_addr.size(), 3);
        if (q_addr.size() == 3) begin
            chk("bp_addr0", q_addr[0], 21'd3);
            chk("bp_data0", q_data[0][255:240], 16'h3333);
            chk("bp_addr1", q_addr[1], 21'd4);
            chk("bp_sel1", q_sel[1], 16'h4000);
            chk("bp_data1", q_data[1][239:224], 16'h4444);
            chk("bp_addr2", q_addr[2], 21'd6);
            chk("bp_sel2", q_sel[2], 16'h2000);
            chk("bp_data2", q_data[2][223:208], 16'h6666);
        end

        // Rewrite of one slot
        clear_q();
        send_pix(21'd11, 4'd7, 16'h1111);
        send_pix(21'd11, 4'd7, 16'h2222);
        do_flush();
        idle(3);
        chk("rw_count", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
            chk("rw_sel", q_sel[0], 16'h0100);
            chk("rw_slot7", q_data[0][143:128], 16'h2222);
        end

        // Reset with a partial buffer and a pending burst
        clear_q();
        pipe_ack_i = 1'b0;
        send_pix(21'd7, 4'd1, 16'h7777);
        send_pix(21'd8, 4'd2, 16'h8888);
        sys_rst = 1'b1;
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        @(negedge clk);
        chk("rst2_stb_o", pipe_stb_o, 1'b0);
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_ack_o", pipe_ack_o, 1'b1);
        pipe_ack_i = 1'b1;
        @(posedge clk);
        #1;
        do_flush();
        idle(3);
        chk("rst2_count", q_addr.size(), 0);

        // Idle behaviour of a lone pixel
        clear_q();
        send_pix(21'd9, 4'd5, 16'h9999);
`ifdef TMU2_BURST_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pipe_stb_o && n < 100);
        chk("timeout_latency", n, 65);
        idle(3);
        chk("timeout_count", q_addr.size(), 1);
`else
        idle(80);
        @(negedge clk);
        chk("no_timeout_stb_o", pipe_stb_o, 1'b0);
        chk("no_timeout_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        do_flush();
        idle(3);
        chk("no_timeout_count", q_addr.size(), 1);
`endif
        if (q_addr.size() == 1) begin
            chk("lone_addr", q_addr[0], 21'd9);
            chk("lone_sel", q_sel[0], 16'h0400);
            chk("lone_data", q_data[0][175:160], 16'h9999);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
